// File: rtl/regfile_mp.sv
// Multi-write-port integer register file with same-cycle bypass, highest-port-wins
// write priority and a sequential clear engine that zeroes entries 1..DEPTH-1.
module regfile_mp #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_WR     = 2,
    parameter int BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear_req,
    output logic                         ready,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0]        rd_addr_1,
    input  logic [ADDR_WIDTH-1:0]        rd_addr_2,
    output logic [DATA_WIDTH-1:0]        rd_data_1,
    output logic [DATA_WIDTH-1:0]        rd_data_2,
    input  logic [ADDR_WIDTH-1:0]        dbg_addr,
    output logic [DATA_WIDTH-1:0]        dbg_data
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] IDX_FIRST = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_LAST  = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                  state_r, state_s;
    logic [ADDR_WIDTH-1:0]   clr_idx_r, clr_idx_s;
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];
    logic                    run_s;
    logic                    wr_allow_s;

    assign run_s      = (state_r == RUN);
    // A clear request takes the edge, so any write presented alongside it is lost.
    assign wr_allow_s = run_s && !clear_req;
    assign ready      = run_s;

    // State and clear-index registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= CLEAR;
            clr_idx_r <= IDX_FIRST;
        end else begin
            state_r   <= state_s;
            clr_idx_r <= clr_idx_s;
        end
    end

    // Next-state logic for the clear engine.
    always_comb begin
        state_s   = state_r;
        clr_idx_s = clr_idx_r;
        case (state_r)
            CLEAR: begin
                if (clr_idx_r == IDX_LAST) begin
                    state_s   = RUN;
                    clr_idx_s = IDX_FIRST;
                end else begin
                    clr_idx_s = clr_idx_r + IDX_FIRST;
                end
            end
            RUN: begin
                if (clear_req) begin
                    state_s   = CLEAR;
                    clr_idx_s = IDX_FIRST;
                end else begin
                    state_s   = RUN;
                end
            end
            default: begin
                state_s   = CLEAR;
                clr_idx_s = IDX_FIRST;
            end
        endcase
    end

    // Storage: clear sweep or port writes; later ports override earlier ones on a collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_r == CLEAR) begin
                mem_r[clr_idx_r] <= '0;
            end else if (wr_allow_s) begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (wr_en[p] && (wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
                        mem_r[wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[p*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    // Read ports: stored value, then bypass from the highest-index matching write port.
    always_comb begin
        rd_data_1 = '0;
        rd_data_2 = '0;
        dbg_data  = '0;
        if (run_s) begin
            rd_data_1 = (rd_addr_1 != '0) ? mem_r[rd_addr_1] : '0;
            rd_data_2 = (rd_addr_2 != '0) ? mem_r[rd_addr_2] : '0;
            dbg_data  = (dbg_addr  != '0) ? mem_r[dbg_addr]  : '0;
            if (BYPASS != 0) begin
                for (int p = 0; p < NUM_WR; p++) begin
                    rd_data_1 = (wr_en[p] && (rd_addr_1 != '0) &&
                                 (wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr_1))
                                ? wr_data[p*DATA_WIDTH +: DATA_WIDTH] : rd_data_1;
                    rd_data_2 = (wr_en[p] && (rd_addr_2 != '0) &&
                                 (wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr_2))
                                ? wr_data[p*DATA_WIDTH +: DATA_WIDTH] : rd_data_2;
                end
            end else begin
                rd_data_1 = rd_data_1;
            end
        end else begin
            dbg_data = '0;
        end
    end

endmodule
